// File: rtl/frodo_decode_stream_if.sv
// Stream bundle for the Frodo decoder: coefficient words in, packed key words out.
interface frodo_decode_stream_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  // master drives coefficients and consumes packed words; slave is the decoder
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/frodo_decode_stream.sv
// Frodo key decoder: rounds each 16-bit coefficient to B bits and packs the
// results LSB-first into 64-bit words, one 8x8 block per start.
module frodo_decode_stream #(
  parameter int DATA_WIDTH = 64,
  parameter int NCOEF      = 64,
  parameter int IN_WORDS   = NCOEF / 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [1:0]           level,
  frodo_decode_stream_if.slave bus,
  output logic                 busy,
  output logic                 done
);
  localparam int ACC_W = DATA_WIDTH + 16;
  localparam logic [4:0] LAST_WORDS = 5'(IN_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                state_reg;
  logic [4:0]            d_reg;
  logic [2:0]            b_reg;
  logic [3:0]            s_reg;
  logic [4:0]            words_in_reg;
  logic [6:0]            fill_reg;
  logic [ACC_W-1:0]      acc_reg;
  logic [2:0]            out_cnt_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic                  in_ready_w;
  logic                  in_accept;
  logic                  out_fire;
  logic                  emit_pend;
  logic [15:0]           d_mask;
  logic [16:0]           round_add;
  logic [3:0]            b_mask;
  logic [3:0]            r [4];
  logic [15:0]           pack;
  logic [ACC_W-1:0]      pack_ext;
  logic [6:0]            step;
  logic [ACC_W-1:0]      base_acc;
  logic [6:0]            base_fill;
  logic [ACC_W-1:0]      acc_next;
  logic [6:0]            fill_next;

  assign in_ready_w = (state_reg == ST_RUN) && (words_in_reg < LAST_WORDS) &&
                      !(out_valid_reg && !bus.out_ready);
  assign in_accept  = bus.in_valid && in_ready_w;
  assign out_fire   = out_valid_reg && bus.out_ready;

  assign d_mask    = (d_reg == 5'd15) ? 16'h7FFF : 16'hFFFF;
  assign round_add = 17'd1 << (s_reg - 4'd1);

  always_comb begin
    b_mask = 4'hF;
    case (b_reg)
      3'd2:    b_mask = 4'h3;
      3'd3:    b_mask = 4'h7;
      default: b_mask = 4'hF;
    endcase
  end

  // The 17-bit sum keeps the carry so that values near q wrap to 0 after masking.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_coef
      logic [16:0] sum;
      assign sum   = {1'b0, bus.in_data[16*gi +: 16] & d_mask} + round_add;
      assign r[gi] = 4'(sum >> s_reg) & b_mask;
    end
  endgenerate

  always_comb begin
    pack = '0;
    case (b_reg)
      3'd2:    pack = {8'h00, r[3][1:0], r[2][1:0], r[1][1:0], r[0][1:0]};
      3'd3:    pack = {4'h0, r[3][2:0], r[2][2:0], r[1][2:0], r[0][2:0]};
      default: pack = {r[3], r[2], r[1], r[0]};
    endcase
  end

  assign pack_ext = {{(ACC_W-16){1'b0}}, pack};
  assign step     = {2'b00, b_reg, 2'b00};

  // A full word sitting in the accumulator is emitted one edge after the absorb
  // that completed it; the out slot is always free then because in_ready blocked
  // absorbing while the slot was stalled.
  assign emit_pend = (fill_reg >= 7'd64);
  assign base_acc  = emit_pend ? (acc_reg >> DATA_WIDTH) : acc_reg;
  assign base_fill = emit_pend ? (fill_reg - 7'd64) : fill_reg;
  assign acc_next  = in_accept ? (base_acc | (pack_ext << base_fill)) : base_acc;
  assign fill_next = in_accept ? (base_fill + step) : base_fill;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      d_reg         <= '0;
      b_reg         <= '0;
      s_reg         <= '0;
      words_in_reg  <= '0;
      fill_reg      <= '0;
      acc_reg       <= '0;
      out_cnt_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start && level != 2'd3) begin
            case (level)
              2'd0:    begin d_reg <= 5'd15; b_reg <= 3'd2; s_reg <= 4'd13; end
              2'd1:    begin d_reg <= 5'd16; b_reg <= 3'd3; s_reg <= 4'd13; end
              default: begin d_reg <= 5'd16; b_reg <= 3'd4; s_reg <= 4'd12; end
            endcase
            words_in_reg <= '0;
            fill_reg     <= '0;
            acc_reg      <= '0;
            out_cnt_reg  <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (emit_pend) begin
            out_data_reg  <= acc_reg[DATA_WIDTH-1:0];
            out_valid_reg <= 1'b1;
          end else if (out_fire) begin
            out_valid_reg <= 1'b0;
          end
          // B output words per block, so the B-th handshake ends the block
          if (out_fire) begin
            out_cnt_reg <= out_cnt_reg + 3'd1;
            if (out_cnt_reg + 3'd1 == b_reg) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end
          end
          if (in_accept) begin
            words_in_reg <= words_in_reg + 5'd1;
          end
          acc_reg  <= acc_next;
          fill_reg <= fill_next;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
endmodule

// File: doc/frodo_decode_stream.md
Name: frodo_decode_stream

Overview:
- Streaming Frodo key decoder; the inverse of the Encode block.
- Takes 64-bit words of four 16-bit coefficients from the Control datapath. Each coefficient is rounded to B bits: decoded = round(c·2^B/q) mod 2^B.
- Decoded bits are packed LSB-first into 64-bit output words for write-back to RAM through Control (data_decode / decode_en path).
- Handles one 8x8 block per start: 64 coefficients in, B·64 bits out.

Parameters:
- DATA_WIDTH, 64, width of input and output words (four 16-bit coefficients per input word).
- NCOEF, 64, coefficients per block (nbar·nbar).
- IN_WORDS, NCOEF/4 = 16, input words per block.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a block and latches level (ignored unless in IDLE)
- level  input  2  0 = Frodo-640 (D=15, B=2); 1 = Frodo-976 (D=16, B=3); 2 = Frodo-1344 (D=16, B=4); 3 reserved
- in_data  input  64  coefficient i = in_data[16i+15:16i], i = 0..3
- in_valid  input  1  in_data valid
- in_ready  output  1  decoder accepts in_data this cycle
- out_data  output  64  packed decoded bits
- out_valid  output  1  out_data valid, held until accepted
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse at block completion

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rstn). All outputs 0 on reset. Reset mid-block aborts it: FSM returns to IDLE, all counters and accumulator cleared, no done.
- FSM:
  - IDLE: start with level != 3 → RUN. Latch D, B, shift S = D−B; clear word counter, fill count and accumulator.
  - start with level == 3 is ignored; FSM stays in IDLE.
  - RUN: after 16 inputs are accepted and the last output handshake completes → DONE.
  - DONE: done = 1 for one cycle → IDLE.
- Per-coefficient arithmetic:
  - c' = c mod 2^D (D=15 masks bit 15).
  - r = (c' + 2^(S−1)) >> S, computed 17 bits wide, then taken mod 2^B.
  - Wrap is required: for example, level 2 with c = 0xF800 gives r = 0.
- Packing:
  - One input word contributes 4·B bits, ordered {r3, r2, r1, r0} with r0 at the lowest bits.
  - These bits are appended above the current fill in an 80-bit accumulator.
  - Bit k of the block stream is out word k/64, bit k%64.
- Input handshake:
  - in_ready = (state == RUN) && (words_in < 16) && !(out_valid && !out_ready).
  - A transfer occurs when in_valid && in_ready.
- Output:
  - When fill ≥ 64 after an absorb, the low 64 bits go to out_data on the next edge, out_valid = 1, and the accumulator shifts right by 64.
  - Latency: accept at edge t → out_valid visible after edge t+1.
  - out_valid drops on the handshake edge unless a new word loads on the same edge.
  - Simultaneous output handshake and input accept is allowed.
  - Max remainder after emit is < 16 bits, so no overflow.
- Totals: 2 / 3 / 4 output words for B = 2 / 3 / 4. Fill is exactly 0 at block end, so no flush state is needed.
- in_valid is ignored outside RUN; start is ignored while busy.
- done is asserted the cycle after the final out handshake; busy falls with done.

Test Plan:
- Level 0, 16 words of 0x6000_6000_6000_6000 → each coefficient decodes to 3; two outputs of 0xFFFF_FFFF_FFFF_FFFF; done one cycle after the second handshake.
- Level 2, word 0 = 0x3000_2000_1000_0000, rest 0 → out word 0 = 0x0000_0000_0000_3210; words 1–3 = 0; done after 4 outputs.
- Level 1, all coefficients 0x2000 → r = 1 (3'b001 repeated); three outputs 0x9249_2492_4924_9249, 0x4924_9249_2492_4924, 0x2492_4924_9249_2492.
- Rounding and wrap:
  - level 2, c = 0xF800 → 0.
  - level 0, c = 0x8000 → 0 (bit 15 masked).
  - level 0, c = 0x0FFF → 0.
  - level 0, c = 0x1000 → 1.
- Backpressure: out_ready held 0 for 10 cycles after the first out_valid → in_ready = 0 and out_data stable throughout. Release out_ready → stream resumes, no data lost or duplicated; randomized in_valid/out_ready matches the reference model.
- Reset and illegal start:
  - rstn low after 5 inputs → all outputs 0, FSM in IDLE; a new start decodes correctly.
  - start with level = 3 → busy stays 0.
